if_prefetch_queue: RTL and testbench

Instruction prefetch stage directly upstream of the IF/ID pipeline register. It issues sequential fetch requests to instruction memory and buffers the returned instructions, each tagged with its PC, in an in-order queue. It presents the head entry to IF/ID, holds it while IF/ID is stalled, and on a taken branch or jump discards all buffered and in-flight fetches before restarting at the target.

---
 rtl/if_prefetch_queue_pkg.sv | 18 +
 rtl/if_prefetch_queue_fifo.sv | 61 ++++++
 rtl/if_prefetch_queue.sv | 94 +++++++++
 tb/tb_if_prefetch_queue.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: data width, NOP
// encoding, queue entry layout and counter sizing.
package if_prefetch_queue_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  // Occupancy counters must represent the value DEPTH itself, hence the extra bit.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_prefetch_queue_fifo.sv
// In-order {pc, instr} buffer: registered storage, synchronous clear, no
// write-to-head bypass, so a pushed entry becomes visible the next cycle.
module pc_instr_fifo
  import if_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  entry_t                   push_dat_i,
  input  logic                     pop_i,
  output entry_t                   head_o,
  output logic [cnt_w(DEPTH)-1:0]  count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// Sequential instruction prefetcher feeding IF/ID: credit-limited requests,
// in-order response queue, and flush of queued/in-flight fetches on redirect.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            IFWrite,
  output logic [XLEN-1:0] Instruction_if,
  output logic [XLEN-1:0] PC,
  output logic            if_valid,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata
);

  localparam int            CW      = cnt_w(DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count;
  logic            grant, stale, push, pop;
  entry_t          head;
  entry_t          push_dat;

  // Queue slots and outstanding requests share one credit pool.
  assign imem_req  = !reset && !redirect &&
                     (({1'b0, count} + {1'b0, inflight_q}) < DEPTH_C);
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;
  assign stale     = imem_rvalid && (discard_q != '0);
  assign push      = imem_rvalid && !stale && !redirect;
  assign if_valid  = (count != '0);
  assign pop       = if_valid && IFWrite && !redirect;
  assign push_dat  = '{pc: resp_pc_q, instr: imem_rdata};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc & ~32'h3;
      resp_pc_d  = redirect_pc & ~32'h3;
      // Everything still owed, minus a response consumed this cycle, becomes stale.
      discard_d  = discard_q + inflight_q - CW'(imem_rvalid);
      inflight_d = '0;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)  resp_pc_d  = resp_pc_q + 32'd4;
      if (stale) discard_d  = discard_q - CW'(1);
      inflight_d = inflight_q + CW'(grant) - CW'(imem_rvalid && !stale);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  pc_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (reset),
    .clr_i      (redirect),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count)
  );

  assign Instruction_if = if_valid ? head.instr : NOP;
  assign PC             = if_valid ? head.pc    : fetch_pc_q;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench with an in-order memory model and a scoreboard of the PCs
// IF/ID is expected to accept.
module tb_if_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset, redirect, IFWrite, imem_gnt, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic [31:0] Instruction_if, PC, imem_addr;
  logic        if_valid, imem_req;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  int cyc = 0;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pq[$];
  logic [31:0] exp_q[$];

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .IFWrite(IFWrite), .Instruction_if(Instruction_if), .PC(PC),
    .if_valid(if_valid), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory model: responses in order, lat cycles after the granting edge.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (!reset && pq.size() > 0 && pq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = ins(pq[0].addr);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
      #2;
      if (reset) pq.delete();
      else begin
        if (imem_rvalid) void'(pq.pop_front());
        if (imem_req && imem_gnt) pq.push_back('{addr: imem_addr, due: cyc + lat});
      end
      cyc++;
    end
  end

  // Monitor: every accepted head is compared against the scoreboard.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (!reset && if_valid && IFWrite && !redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mon_unexpected actual_pc=%h required=none", PC);
        end else begin
          e = exp_q.pop_front();
          chk("mon_pc", PC, e);
          chk("mon_instr", Instruction_if, ins(e));
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int g;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; IFWrite = 1'b1; imem_gnt = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", Instruction_if, 32'h0000_0013);
    chk("rst_pc", PC, 32'h0);

    // Streaming, one-cycle memory.
    @(negedge clk);
    reset = 1'b0;
    lat = 1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t1_req", 32'(imem_req), 32'd1);
      chk("t1_addr", imem_addr, 32'(4 * i));
      if (i >= 2) begin
        chk("t1_valid", 32'(if_valid), 32'd1);
        chk("t1_pc", PC, 32'(4 * (i - 2)));
      end
      @(negedge clk);
    end

    // IF/ID stalled: credit limit stops fetch, then drain.
    do_reset();
    g = 0;
    for (int k = 0; k < 6; k++) exp_q.push_back(32'(4 * k));
    for (int i = 0; i < 16; i++) begin
      IFWrite = (i >= 10);
      #1;
      if (i < 10) begin
        chk("t2_req", 32'(imem_req), 32'(i < 4));
        if (imem_req && imem_gnt) g++;
      end
      if (i >= 2 && i < 10) begin
        chk("t2_hold_valid", 32'(if_valid), 32'd1);
        chk("t2_hold_pc", PC, 32'h0);
      end
      if (i >= 10) chk("t2_drain_pc", PC, 32'(4 * (i - 10)));
      @(negedge clk);
    end
    chk("t2_grants", 32'(g), 32'd4);

    // Redirect with three requests in flight on a slow memory.
    do_reset();
    lat = 4;
    IFWrite = 1'b1;
    redirect_pc = 32'h100;
    for (int k = 0; k < 4; k++) exp_q.push_back(32'h100 + 32'(4 * k));
    for (int i = 0; i < 13; i++) begin
      redirect = (i == 3);
      #1;
      if (i == 3) chk("t3_req_redir", 32'(imem_req), 32'd0);
      if (i == 4) begin
        chk("t3_req_target", 32'(imem_req), 32'd1);
        chk("t3_addr_target", imem_addr, 32'h100);
      end
      if (i <= 8) chk("t3_no_stale", 32'(if_valid), 32'd0);
      if (i >= 9) chk("t3_pc", PC, 32'h100 + 32'(4 * (i - 9)));
      @(negedge clk);
    end

    // Redirect coinciding with a response plus one outstanding; unaligned target.
    do_reset();
    lat = 2;
    redirect_pc = 32'h203;
    exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    for (int i = 0; i < 8; i++) begin
      redirect = (i == 2);
      #1;
      if (i == 3) chk("t4_addr_aligned", imem_addr, 32'h200);
      if (i >= 3 && i <= 5) chk("t4_no_stale", 32'(if_valid), 32'd0);
      if (i >= 6) chk("t4_pc", PC, 32'h200 + 32'(4 * (i - 6)));
      @(negedge clk);
    end

    // Address wrap at the top of the address space.
    do_reset();
    lat = 1;
    redirect_pc = 32'hFFFF_FFF8;
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);         exp_q.push_back(32'h4);
    for (int i = 0; i < 7; i++) begin
      redirect = (i == 0);
      #1;
      if (i >= 1) chk("t5_addr", imem_addr, 32'hFFFF_FFF8 + 32'(4 * (i - 1)));
      if (i == 1) chk("t5_valid_off", 32'(if_valid), 32'd0);
      if (i >= 3) chk("t5_pc", PC, 32'hFFFF_FFF8 + 32'(4 * (i - 3)));
      @(negedge clk);
    end

    // Reset asserted with a full queue.
    do_reset();
    IFWrite = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i == 7) begin
        chk("t6_full_valid", 32'(if_valid), 32'd1);
        chk("t6_full_req", 32'(imem_req), 32'd0);
      end
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(if_valid), 32'd0);
    chk("t6_rst_req", 32'(imem_req), 32'd0);
    chk("t6_rst_pc", PC, 32'h0);
    chk("t6_rst_instr", Instruction_if, 32'h0000_0013);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    IFWrite = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t6_restart_addr", imem_addr, 32'(4 * i));
      if (i >= 2) chk("t6_restart_pc", PC, 32'(4 * (i - 2)));
      @(negedge clk);
    end

    reset = 1'b1;
    IFWrite = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
